// File: rtl/note_sequencer_if.sv
// Control/status bundle between the note sequencer and its host.
// Handshake: there is no ready/valid pair. wr_en is a single-cycle write
// strobe that is always accepted on the edge where it is sampled high.
// step_pulse is a 1-cycle strobe marking every step load.
// All other controls are levels that are sampled on every edge.
interface note_sequencer_if;
  logic        run;
  logic [7:0]  tempo;
  logic [7:0]  gate_len;
  logic [3:0]  last_step;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [4:0]  wr_data;
  logic [10:0] scale_factor;
  logic        gate;
  logic [3:0]  step_idx;
  logic        step_pulse;
  logic        dbg_state;   // 1 while the sequencer FSM is in PLAY

  modport master (
    output run, tempo, gate_len, last_step, wr_en, wr_addr, wr_data,
    input  scale_factor, gate, step_idx, step_pulse, dbg_state
  );

  modport slave (
    input  run, tempo, gate_len, last_step, wr_en, wr_addr, wr_data,
    output scale_factor, gate, step_idx, step_pulse, dbg_state
  );
endinterface

// File: rtl/note_sequencer.sv
// 16-step note sequencer. It feeds an 11-bit divider reload value and a
// gate line. Steps advance every (tempo+1) prescaled ticks. Each pattern entry
// is a chromatic note index or a rest.
module note_sequencer #(
  parameter int PRESCALE = 1000
) (
  input logic              clk,
  input logic              rst,
  note_sequencer_if.slave  bus
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]  tick_cnt_q, tick_cnt_d;
  logic [3:0]  step_idx_q, step_idx_d;
  logic [10:0] sf_q, sf_d;
  logic        gate_q, gate_d;
  logic        pulse_q, pulse_d;
  logic [4:0]  pattern_q [16];
  logic [4:0]  pattern_d [16];

  logic        tick;
  logic        do_load;
  logic [3:0]  load_idx;
  logic [4:0]  entry;

  // Chromatic divider reload values, C4 up to D#5.
  function automatic logic [10:0] note_lut(input logic [3:0] n);
    case (n)
      4'd0:  note_lut = 11'd1910;
      4'd1:  note_lut = 11'd1803;
      4'd2:  note_lut = 11'd1702;
      4'd3:  note_lut = 11'd1606;
      4'd4:  note_lut = 11'd1516;
      4'd5:  note_lut = 11'd1431;
      4'd6:  note_lut = 11'd1350;
      4'd7:  note_lut = 11'd1275;
      4'd8:  note_lut = 11'd1203;
      4'd9:  note_lut = 11'd1135;
      4'd10: note_lut = 11'd1072;
      4'd11: note_lut = 11'd1011;
      4'd12: note_lut = 11'd955;
      4'd13: note_lut = 11'd901;
      4'd14: note_lut = 11'd850;
      default: note_lut = 11'd803;
    endcase
  endfunction

  assign tick = (presc_q == PW'(PRESCALE - 1));

  // State and datapath registers; reset restores IDLE and an all-rest pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      step_idx_q <= '0;
      sf_q       <= '0;
      gate_q     <= 1'b0;
      pulse_q    <= 1'b0;
      for (int i = 0; i < 16; i++) pattern_q[i] <= 5'h10;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      step_idx_q <= step_idx_d;
      sf_q       <= sf_d;
      gate_q     <= gate_d;
      pulse_q    <= pulse_d;
      pattern_q  <= pattern_d;
    end
  end

  // Pattern writes land at the edge, so a same-cycle step load sees the old entry.
  always_comb begin
    pattern_d = pattern_q;
    if (bus.wr_en) pattern_d[bus.wr_addr] = bus.wr_data;
  end

  // Next state: run is a plain level that selects PLAY or IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.run)  state_d = PLAY;
      PLAY:    if (!bus.run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and counters: start/stop handling, tick counting, gate-off, step loads.
  always_comb begin
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    step_idx_d = step_idx_q;
    sf_d       = sf_q;
    gate_d     = gate_q;
    pulse_d    = 1'b0;
    do_load    = 1'b0;
    load_idx   = step_idx_q;
    case (state_q)
      IDLE: begin
        if (bus.run) begin
          do_load    = 1'b1;
          load_idx   = 4'd0;
          presc_d    = '0;
          tick_cnt_d = '0;
        end
      end
      PLAY: begin
        if (!bus.run) begin
          // scale_factor deliberately holds its last value when stopping
          gate_d     = 1'b0;
          step_idx_d = 4'd0;
          presc_d    = '0;
          tick_cnt_d = '0;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (tick_cnt_q == bus.tempo) begin
              do_load    = 1'b1;
              // >= also catches last_step being lowered below the current step
              load_idx   = (step_idx_q >= bus.last_step) ? 4'd0 : step_idx_q + 4'd1;
              tick_cnt_d = '0;
            end else begin
              tick_cnt_d = tick_cnt_q + 8'd1;
              if (({1'b0, tick_cnt_q} + 9'd1) == {1'b0, bus.gate_len}) gate_d = 1'b0;
            end
          end
        end
      end
      default: ;
    endcase
    entry = pattern_q[load_idx];
    if (do_load) begin
      step_idx_d = load_idx;
      sf_d       = note_lut(entry[3:0]);
      gate_d     = ~entry[4] & (bus.gate_len != 8'd0);
      pulse_d    = 1'b1;
    end
  end

  assign bus.scale_factor = sf_q;
  assign bus.gate         = gate_q;
  assign bus.step_idx     = step_idx_q;
  assign bus.step_pulse   = pulse_q;
  assign bus.dbg_state    = (state_q == PLAY);

endmodule
